// File: rtl/encoder8x3_pkg.sv
// Shared constants, controller state encoding and helpers for the 8->3 request queue.
package encoder8x3_pkg;

  localparam int NUM_REQ = 8;
  localparam int CODE_W  = 3;
  localparam int CNT_W   = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REQ-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encoder8x3_queue_pri_enc8.sv
// Combinational 8->3 priority encoder; HI_FIRST selects whether D7 or D0 wins.
module pri_enc8
  import encoder8x3_pkg::*;
#(
  parameter int HI_FIRST = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  output logic [CODE_W-1:0]  o_idx,
  output logic               o_any
);

  // Scan toward the winning end so the last hit seen is the highest priority.
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    if (HI_FIRST != 0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i_req[i]) o_idx = i[CODE_W-1:0];
      end
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = i[CODE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/encoder8x3_queue.sv
// Edge-captured request queue: rising request lines are latched as pending and
// served one code at a time in priority order through a valid/ready output slot.
module encoder8x3_queue
  import encoder8x3_pkg::*;
#(
  parameter int HI_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] d,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  input  logic               ready,
  output logic [CNT_W-1:0]   pend_cnt,
  output logic               drop,
  output logic               idle
);

  logic [NUM_REQ-1:0] r_d_q;
  logic [NUM_REQ-1:0] r_pending;
  logic [CODE_W-1:0]  r_code;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_drop;
  state_t             r_state;

  state_t             w_state_next;
  logic [NUM_REQ-1:0] w_rise;
  logic [NUM_REQ-1:0] w_clr;
  logic [NUM_REQ-1:0] w_pend_next;
  logic [CODE_W-1:0]  w_win_idx;
  logic               w_win_any;
  logic               w_slot_free;
  logic               w_load;
  logic               w_drop;

  pri_enc8 #(
    .HI_FIRST (HI_FIRST)
  ) u_pri_enc8 (
    .i_req (r_pending),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  assign w_rise      = d & ~r_d_q;
  assign w_slot_free = ~valid | ready;
  assign w_load      = w_slot_free & w_win_any;

  always_comb begin
    w_clr = '0;
    if (w_load) w_clr[w_win_idx] = 1'b1;
  end

  // A rise on a bit being loaded re-sets it; a rise on an untouched pending bit is lost.
  assign w_pend_next = (r_pending & ~w_clr) | w_rise;
  assign w_drop      = |(w_rise & r_pending & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_q     <= '0;
      r_pending <= '0;
      r_cnt     <= '0;
      r_drop    <= 1'b0;
      r_code    <= '0;
    end else begin
      r_d_q     <= d;
      r_pending <= w_pend_next;
      r_cnt     <= popcount(w_pend_next);
      r_drop    <= w_drop;
      if (w_load) r_code <= w_win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_next;
  end

  // Stay in HOLD while stalled or reloading; fall to EMPTY only when nothing is loaded.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY:   if (w_load) w_state_next = HOLD;
      HOLD:    if (ready && !w_win_any) w_state_next = EMPTY;
      default: w_state_next = EMPTY;
    endcase
  end

  always_comb begin
    valid = (r_state == HOLD);
  end

  assign code     = r_code;
  assign pend_cnt = r_cnt;
  assign drop     = r_drop;
  assign idle     = (r_pending == '0) & ~valid;

endmodule

// File: tb/tb_encoder8x3_queue.sv
// Directed bench for encoder8x3_queue with hand-computed expectations per scenario.
module tb_encoder8x3_queue;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic [3:0] pend_cnt;
  logic       drop;
  logic       idle;

  int n_pass  = 0;
  int n_total = 0;

  encoder8x3_queue #(.HI_FIRST(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .code     (code),
    .valid    (valid),
    .ready    (ready),
    .pend_cnt (pend_cnt),
    .drop     (drop),
    .idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; d = 8'h00; ready = 1'b0;
    #3;
    n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid); else n_pass++;
    n_total++; if (code !== 3'd0) $display("FAIL reset_code: got %0d want 0", code); else n_pass++;
    n_total++; if (pend_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", pend_cnt); else n_pass++;
    n_total++; if (drop !== 1'b0) $display("FAIL reset_drop: got %0b want 0", drop); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL reset_idle: got %0b want 1", idle); else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    d = 8'h04; ready = 1'b1;
    tick();
    d = 8'h00;
    n_total++; if (pend_cnt !== 4'd1) $display("FAIL single_cnt_E: got %0d want 1", pend_cnt); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL single_valid_E: got %0b want 0", valid); else n_pass++;
    n_total++; if (idle !== 1'b0) $display("FAIL single_idle_E: got %0b want 0", idle); else n_pass++;
    tick();
    n_total++; if (valid !== 1'b1 || code !== 3'd2) $display("FAIL single_load: got v=%0b c=%0d want v=1 c=2", valid, code); else n_pass++;
    n_total++; if (pend_cnt !== 4'd0) $display("FAIL single_cnt_E1: got %0d want 0", pend_cnt); else n_pass++;
    tick();
    n_total++; if (valid !== 1'b0 || idle !== 1'b1) $display("FAIL single_done: got v=%0b idle=%0b want v=0 idle=1", valid, idle); else n_pass++;
  endtask

  task automatic test_burst;
    logic [2:0] exp_code [4];
    exp_code = '{3'd7, 3'd5, 3'd2, 3'd0};
    d = 8'hA5; ready = 1'b1;
    tick();
    d = 8'h00;
    n_total++; if (pend_cnt !== 4'd4) $display("FAIL burst_cnt0: got %0d want 4", pend_cnt); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_total++;
      if (valid !== 1'b1 || code !== exp_code[k] || pend_cnt !== 4'(3 - k))
        $display("FAIL burst_step%0d: got v=%0b c=%0d cnt=%0d want v=1 c=%0d cnt=%0d",
                 k, valid, code, pend_cnt, exp_code[k], 3 - k);
      else n_pass++;
    end
    tick();
    n_total++; if (valid !== 1'b0 || idle !== 1'b1) $display("FAIL burst_end: got v=%0b idle=%0b want v=0 idle=1", valid, idle); else n_pass++;
  endtask

  task automatic test_backpressure;
    d = 8'h81; ready = 1'b0;
    tick();
    d = 8'h00;
    n_total++; if (pend_cnt !== 4'd2) $display("FAIL bp_cnt0: got %0d want 2", pend_cnt); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++;
      if (valid !== 1'b1 || code !== 3'd7 || pend_cnt !== 4'd1)
        $display("FAIL bp_hold%0d: got v=%0b c=%0d cnt=%0d want v=1 c=7 cnt=1", k, valid, code, pend_cnt);
      else n_pass++;
    end
    ready = 1'b1;
    tick();
    n_total++; if (valid !== 1'b1 || code !== 3'd0 || pend_cnt !== 4'd0) $display("FAIL bp_next: got v=%0b c=%0d cnt=%0d want v=1 c=0 cnt=0", valid, code, pend_cnt); else n_pass++;
    tick();
    n_total++; if (valid !== 1'b0) $display("FAIL bp_end: got v=%0b want 0", valid); else n_pass++;
  endtask

  task automatic test_drop;
    d = 8'h88; ready = 1'b0;
    tick();
    d = 8'h00;
    n_total++; if (pend_cnt !== 4'd2) $display("FAIL drop_cnt0: got %0d want 2", pend_cnt); else n_pass++;
    tick();
    n_total++; if (valid !== 1'b1 || code !== 3'd7 || pend_cnt !== 4'd1) $display("FAIL drop_setup: got v=%0b c=%0d cnt=%0d want v=1 c=7 cnt=1", valid, code, pend_cnt); else n_pass++;
    d = 8'h08;
    tick();
    d = 8'h00;
    n_total++; if (drop !== 1'b1 || pend_cnt !== 4'd1) $display("FAIL drop_pulse: got drop=%0b cnt=%0d want drop=1 cnt=1", drop, pend_cnt); else n_pass++;
    tick();
    n_total++; if (drop !== 1'b0 || pend_cnt !== 4'd1) $display("FAIL drop_clear: got drop=%0b cnt=%0d want drop=0 cnt=1", drop, pend_cnt); else n_pass++;
    d = 8'h80;
    tick();
    d = 8'h00;
    n_total++; if (drop !== 1'b0 || pend_cnt !== 4'd2 || code !== 3'd7) $display("FAIL drop_same_code: got drop=%0b cnt=%0d c=%0d want drop=0 cnt=2 c=7", drop, pend_cnt, code); else n_pass++;
    ready = 1'b1;
    tick();
    n_total++; if (valid !== 1'b1 || code !== 3'd7 || pend_cnt !== 4'd1) $display("FAIL drop_drain7: got v=%0b c=%0d cnt=%0d want v=1 c=7 cnt=1", valid, code, pend_cnt); else n_pass++;
    tick();
    n_total++; if (valid !== 1'b1 || code !== 3'd3 || pend_cnt !== 4'd0) $display("FAIL drop_drain3: got v=%0b c=%0d cnt=%0d want v=1 c=3 cnt=0", valid, code, pend_cnt); else n_pass++;
    tick();
    n_total++; if (valid !== 1'b0) $display("FAIL drop_end: got v=%0b want 0", valid); else n_pass++;
  endtask

  task automatic test_set_wins;
    d = 8'h80; ready = 1'b0;
    tick();
    d = 8'h00;
    tick();
    d = 8'h40;
    tick();
    d = 8'h00;
    tick();
    n_total++; if (valid !== 1'b1 || code !== 3'd7 || pend_cnt !== 4'd1) $display("FAIL sw_setup: got v=%0b c=%0d cnt=%0d want v=1 c=7 cnt=1", valid, code, pend_cnt); else n_pass++;
    d = 8'h40; ready = 1'b1;
    tick();
    d = 8'h00;
    n_total++; if (valid !== 1'b1 || code !== 3'd6 || pend_cnt !== 4'd1 || drop !== 1'b0) $display("FAIL sw_first: got v=%0b c=%0d cnt=%0d drop=%0b want v=1 c=6 cnt=1 drop=0", valid, code, pend_cnt, drop); else n_pass++;
    tick();
    n_total++; if (valid !== 1'b1 || code !== 3'd6 || pend_cnt !== 4'd0) $display("FAIL sw_second: got v=%0b c=%0d cnt=%0d want v=1 c=6 cnt=0", valid, code, pend_cnt); else n_pass++;
    tick();
    n_total++; if (valid !== 1'b0) $display("FAIL sw_end: got v=%0b want 0", valid); else n_pass++;
  endtask

  task automatic test_async_reset;
    d = 8'hFF; ready = 1'b1;
    tick();
    n_total++; if (pend_cnt !== 4'd8) $display("FAIL ar_cnt8: got %0d want 8", pend_cnt); else n_pass++;
    tick();
    n_total++; if (valid !== 1'b1 || code !== 3'd7 || pend_cnt !== 4'd7) $display("FAIL ar_first: got v=%0b c=%0d cnt=%0d want v=1 c=7 cnt=7", valid, code, pend_cnt); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (valid !== 1'b0 || pend_cnt !== 4'd0 || code !== 3'd0 || idle !== 1'b1) $display("FAIL ar_immediate: got v=%0b cnt=%0d c=%0d idle=%0b want v=0 cnt=0 c=0 idle=1", valid, pend_cnt, code, idle); else n_pass++;
    tick();
    rst_n = 1'b1;
    n_total++; if (valid !== 1'b0 || pend_cnt !== 4'd0) $display("FAIL ar_deassert: got v=%0b cnt=%0d want v=0 cnt=0", valid, pend_cnt); else n_pass++;
    tick();
    n_total++; if (pend_cnt !== 4'd8 || valid !== 1'b0) $display("FAIL ar_restart: got cnt=%0d v=%0b want cnt=8 v=0", pend_cnt, valid); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_total++;
      if (valid !== 1'b1 || code !== 3'(7 - k) || pend_cnt !== 4'(7 - k))
        $display("FAIL ar_code%0d: got v=%0b c=%0d cnt=%0d want v=1 c=%0d cnt=%0d",
                 k, valid, code, pend_cnt, 7 - k, 7 - k);
      else n_pass++;
    end
    tick();
    n_total++; if (valid !== 1'b0 || idle !== 1'b1) $display("FAIL ar_end: got v=%0b idle=%0b want v=0 idle=1", valid, idle); else n_pass++;
    d = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_drop();
    test_set_wins();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
